// File: rtl/updown_count_ctrl.sv
// updown_count_ctrl
// Owns the 4-bit count register and shares one external up/down adder
// between an increment requester and a decrement requester. Each operation
// takes three cycles: grant in IDLE, drive the adder in EXEC, acknowledge in ACK.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for inc_req/dec_req; arbitrates and registers the op
//   EXEC   | adder driven from registered op; count captured at the edge
//   ACK    | one-cycle inc_ack/dec_ack (plus ovf when a boundary was hit)

module updown_count_ctrl #(
   parameter bit         SATURATE = 1'b1,
   parameter bit         RR_EN    = 1'b1,
   parameter logic [3:0] INIT_VAL = 4'h0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       inc_req,
   input  logic       dec_req,
   output logic       inc_ack,
   output logic       dec_ack,
   output logic       add_up,
   output logic       add_down,
   output logic [3:0] add_in,
   input  logic [3:0] add_out,
   input  logic       add_co,
   output logic [3:0] count,
   output logic       full,
   output logic       empty,
   output logic       busy,
   output logic       ovf
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_ACK  = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] count_q, count_d;
   logic       op_inc_q, op_inc_d;     // 1: op in flight is an increment
   logic       last_inc_q, last_inc_d; // 1: most recent grant went to inc
   logic       ovf_q, ovf_d;           // boundary flag shown during ACK

   logic       req_any;
   logic       grant_inc;
   logic       boundary;
   logic [3:0] next_val;

   // Arbitration: a lone request wins; on a tie, round-robin favours the
   // side not granted last, otherwise inc always wins.
   always_comb begin
      req_any   = inc_req | dec_req;
      grant_inc = 1'b0;
      if (inc_req && !dec_req) begin
         grant_inc = 1'b1;
      end else if (inc_req && dec_req) begin
         grant_inc = RR_EN ? !last_inc_q : 1'b1;
      end
   end

   // Result selection: carry out on inc means 4'hF wrapped, missing carry on
   // dec (in + 4'hF) means 4'h0 borrowed. Saturation just keeps the old value,
   // which is already the clamp value in both cases.
   always_comb begin
      boundary = op_inc_q ? add_co : !add_co;
      next_val = add_out;
      if (boundary && SATURATE) begin
         next_val = count_q;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; clr forces IDLE from any state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req_any) state_d = S_EXEC;
         S_EXEC:  state_d = S_ACK;
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (clr) begin
         state_d = S_IDLE;
      end
   end

   // Datapath registers: op capture, grant history, count and boundary flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= INIT_VAL;
         op_inc_q   <= 1'b0;
         last_inc_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         count_q    <= count_d;
         op_inc_q   <= op_inc_d;
         last_inc_q <= last_inc_d;
         ovf_q      <= ovf_d;
      end
   end

   // Datapath next values; a clr drops the in-flight op before it lands.
   always_comb begin
      count_d    = count_q;
      op_inc_d   = op_inc_q;
      last_inc_d = last_inc_q;
      ovf_d      = ovf_q;
      if (clr) begin
         count_d = INIT_VAL;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_any) begin
                  op_inc_d   = grant_inc;
                  last_inc_d = grant_inc;
               end
            end
            S_EXEC: begin
               count_d = next_val;
               ovf_d   = boundary;
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from registered state only.
   always_comb begin
      add_up   = (state_q == S_EXEC) &&  op_inc_q;
      add_down = (state_q == S_EXEC) && !op_inc_q;
      inc_ack  = (state_q == S_ACK)  &&  op_inc_q;
      dec_ack  = (state_q == S_ACK)  && !op_inc_q;
      ovf      = (state_q == S_ACK)  &&  ovf_q;
      busy     = (state_q != S_IDLE);
   end

   assign add_in = count_q;
   assign count  = count_q;
   assign full   = (count_q == 4'hF);
   assign empty  = (count_q == 4'h0);

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Bench for updown_count_ctrl: two instances (saturating + round-robin with
// INIT 0, and wrapping + fixed-priority with INIT 5), each wired to a
// behavioural 4-bit up/down adder. A transaction-level model predicts every
// acknowledged operation into a queue; a monitor pops and compares on ack.

module tb_updown_count_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]      rst_n, clr, inc_req, dec_req;
   logic [1:0]      inc_ack, dec_ack, add_up, add_down, add_co;
   logic [1:0]      full, empty, busy, ovf;
   logic [1:0][3:0] add_in, add_out, count;

   generate
      for (genvar g = 0; g < 2; g++) begin : g_dut
         logic [4:0] sum;
         assign sum        = add_up[g] ? ({1'b0, add_in[g]} + 5'd1) : ({1'b0, add_in[g]} + 5'd15);
         assign add_out[g] = sum[3:0];
         assign add_co[g]  = sum[4];

         updown_count_ctrl #(
            .SATURATE(g == 0 ? 1'b1 : 1'b0),
            .RR_EN   (g == 0 ? 1'b1 : 1'b0),
            .INIT_VAL(g == 0 ? 4'h0 : 4'h5)
         ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n[g]),
            .clr     (clr[g]),
            .inc_req (inc_req[g]),
            .dec_req (dec_req[g]),
            .inc_ack (inc_ack[g]),
            .dec_ack (dec_ack[g]),
            .add_up  (add_up[g]),
            .add_down(add_down[g]),
            .add_in  (add_in[g]),
            .add_out (add_out[g]),
            .add_co  (add_co[g]),
            .count   (count[g]),
            .full    (full[g]),
            .empty   (empty[g]),
            .busy    (busy[g]),
            .ovf     (ovf[g])
         );
      end
   endgenerate

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int inst;
      int is_inc;
      int cnt;
      int ovf;
      int cyc;
   } exp_t;

   exp_t exp_q[$];

   function automatic int init_of(input int i);
      return (i == 0) ? 0 : 5;
   endfunction
   function automatic int sat_of(input int i);
      return (i == 0) ? 1 : 0;
   endfunction
   function automatic int rr_of(input int i);
      return (i == 0) ? 1 : 0;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: the unit accepts a new request at the first edge where it is free;
   // each accepted op occupies three edges and acks one edge after the grant.
   int m_next_free[2];
   int m_grant_e[2];
   int m_inflight[2];
   int m_count[2];
   int m_last_inc[2];

   task automatic model_reset(input int i);
      exp_t keep[$];
      m_count[i]     = init_of(i);
      m_last_inc[i]  = 0;
      m_next_free[i] = 0;
      m_inflight[i]  = 0;
      foreach (exp_q[k]) if (exp_q[k].inst != i) keep.push_back(exp_q[k]);
      exp_q = keep;
   endtask

   task automatic model_edge(input int i, input int e, input bit ir, input bit dr, input bit c);
      if (c) begin
         if (m_inflight[i] != 0 && e == m_grant_e[i] + 1 && exp_q.size() > 0)
            void'(exp_q.pop_back());
         m_inflight[i]  = 0;
         m_count[i]     = init_of(i);
         m_next_free[i] = e + 1;
      end else if (e >= m_next_free[i] && (ir || dr)) begin
         int   do_inc;
         int   v;
         exp_t x;
         do_inc = (ir && (!dr || rr_of(i) == 0 || m_last_inc[i] == 0)) ? 1 : 0;
         v      = m_count[i] + ((do_inc != 0) ? 1 : -1);
         x.ovf  = (v < 0 || v > 15) ? 1 : 0;
         if (x.ovf != 0 && sat_of(i) != 0) v = (do_inc != 0) ? 15 : 0;
         v        = v & 15;
         x.inst   = i;
         x.is_inc = do_inc;
         x.cnt    = v;
         x.cyc    = e + 1;
         exp_q.push_back(x);
         m_count[i]     = v;
         m_last_inc[i]  = do_inc;
         m_next_free[i] = e + 3;
         m_grant_e[i]   = e;
         m_inflight[i]  = 1;
      end
   endtask

   // Called at a falling edge: sets inputs for the next rising edge.
   task automatic drive_edge(input int i, input bit ir, input bit dr, input bit c);
      inc_req[i] = ir;
      dec_req[i] = dr;
      clr[i]     = c;
      model_edge(i, cyc + 1, ir, dr, c);
      @(negedge clk);
   endtask

   task automatic pulse_op(input int i, input bit is_inc);
      drive_edge(i, is_inc, !is_inc, 1'b0);
      drive_edge(i, 1'b0, 1'b0, 1'b0);
      drive_edge(i, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic hold_both(input int i, input int ncyc);
      for (int k = 0; k < ncyc; k++) drive_edge(i, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) drive_edge(i, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic clr_in_exec(input int i);
      drive_edge(i, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) pulse_op(i, 1'b1);
      drive_edge(i, 1'b1, 1'b0, 1'b0);
      drive_edge(i, 1'b1, 1'b0, 1'b1);
      chk("clr_busy", int'(busy[i]), 0);
      chk("clr_count", int'(count[i]), init_of(i));
      chk("clr_no_ack", int'(inc_ack[i]), 0);
      drive_edge(i, 1'b1, 1'b0, 1'b0);
      drive_edge(i, 1'b1, 1'b0, 1'b0);
      drive_edge(i, 1'b0, 1'b0, 1'b0);
      drive_edge(i, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rand_phase(input int i, input int ncyc);
      bit ir, dr, c;
      ir = 1'b0;
      dr = 1'b0;
      for (int k = 0; k < ncyc; k++) begin
         if (inc_ack[i]) ir = ($urandom_range(0, 2) == 0);
         else if (!ir)   ir = ($urandom_range(0, 3) == 0);
         if (dec_ack[i]) dr = ($urandom_range(0, 2) == 0);
         else if (!dr)   dr = ($urandom_range(0, 3) == 0);
         c = ($urandom_range(0, 29) == 0);
         drive_edge(i, ir, dr, c);
      end
      for (int k = 0; k < 4; k++) drive_edge(i, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: ack-driven scoreboard plus per-cycle adder-direction checks.
   always @(negedge clk) begin : mon
      exp_t x;
      for (int i = 0; i < 2; i++) begin
         if (rst_n[i]) begin
            if (add_up[i] || add_down[i])
               chk("dir_excl", int'(add_up[i] && add_down[i]), 0);
            if (exp_q.size() > 0 && exp_q[0].inst == i && exp_q[0].cyc == cyc + 1) begin
               chk("exec_add_up", int'(add_up[i]), exp_q[0].is_inc);
               chk("exec_add_down", int'(add_down[i]), 1 - exp_q[0].is_inc);
               chk("exec_busy", int'(busy[i]), 1);
            end
            if (inc_ack[i] || dec_ack[i]) begin
               chk("ack_excl", int'(inc_ack[i] && dec_ack[i]), 0);
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL unexpected_ack: inst %0d acked with nothing expected (cycle %0d)", i, cyc);
               end else begin
                  x = exp_q.pop_front();
                  chk("ack_inst", i, x.inst);
                  chk("ack_is_inc", int'(inc_ack[i]), x.is_inc);
                  chk("ack_cycle", cyc, x.cyc);
                  chk("count", int'(count[i]), x.cnt);
                  chk("add_in", int'(add_in[i]), x.cnt);
                  chk("ovf", int'(ovf[i]), x.ovf);
                  chk("full", int'(full[i]), (x.cnt == 15) ? 1 : 0);
                  chk("empty", int'(empty[i]), (x.cnt == 0) ? 1 : 0);
               end
            end else if (ovf[i]) begin
               chk("ovf_without_ack", int'(ovf[i]), 0);
            end
         end
      end
   end

   initial begin
      rst_n   = 2'b00;
      clr     = 2'b00;
      inc_req = 2'b00;
      dec_req = 2'b00;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_count", int'(count[i]), init_of(i));
         chk("rst_busy", int'(busy[i]), 0);
         chk("rst_acks", int'({inc_ack[i], dec_ack[i], ovf[i]}), 0);
         chk("rst_adder", int'({add_up[i], add_down[i]}), 0);
         model_reset(i);
      end
      rst_n = 2'b11;
      @(negedge clk);

      // single increment: latency and busy window
      drive_edge(0, 1'b1, 1'b0, 1'b0);
      chk("t1_busy_exec", int'(busy[0]), 1);
      chk("t1_no_early_ack", int'(inc_ack[0]), 0);
      drive_edge(0, 1'b0, 1'b0, 1'b0);
      chk("t1_busy_ack", int'(busy[0]), 1);
      chk("t1_inc_ack", int'(inc_ack[0]), 1);
      drive_edge(0, 1'b0, 1'b0, 1'b0);
      chk("t1_busy_done", int'(busy[0]), 0);

      // walk to the top, then past it (clamp on 0, wrap on 1)
      for (int k = 0; k < 15; k++) pulse_op(0, 1'b1);
      for (int k = 0; k < 11; k++) pulse_op(1, 1'b1);
      // walk down past the bottom
      for (int k = 0; k < 17; k++) pulse_op(0, 1'b0);
      for (int k = 0; k < 12; k++) pulse_op(1, 1'b0);

      // simultaneous requests around count 7
      for (int k = 0; k < 7; k++) pulse_op(0, 1'b1);
      hold_both(0, 12);
      hold_both(1, 12);

      // clr while an increment is in EXEC
      clr_in_exec(0);
      clr_in_exec(1);

      // async reset in the middle of an op
      drive_edge(0, 1'b1, 1'b0, 1'b0);
      #2 rst_n[0] = 1'b0;
      #1;
      chk("arst_busy", int'(busy[0]), 0);
      chk("arst_adder", int'({add_up[0], add_down[0]}), 0);
      chk("arst_count", int'(count[0]), init_of(0));
      chk("arst_acks", int'({inc_ack[0], dec_ack[0], ovf[0]}), 0);
      model_reset(0);
      inc_req[0] = 1'b0;
      @(negedge clk);
      rst_n[0] = 1'b1;
      @(negedge clk);

      rand_phase(0, 1500);
      rand_phase(1, 1500);

      chk("pending_at_end", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
